// File: rtl/fetch_stage.sv
// Instruction fetch front end: single-outstanding imem requests feeding a prefetch FIFO.
// Define STATIC_BTFN_EN to redirect fetch on backward branches (static BTFN prediction).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        block_signal,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] curr_PC,
    output logic [31:0] instruction,
    output logic [31:0] immediate,
    output logic        pred_taken
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] b_offset(input logic [31:0] i);
        logic [12:0] imm13;
        imm13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (i[6:0] == OP_BRANCH) return {{19{imm13[12]}}, imm13};
        return 32'd0;
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW+1:0] inflight;
    logic [31:0]   pc_mem  [FIFO_DEPTH];
    logic [31:0]   ins_mem [FIFO_DEPTH];
    logic          resp, push, pop, issue, credit_ok, pred_in;

    assign resp      = outstanding_q && imem_rvalid;
    assign push      = resp && !discard_q && !flush;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && !block_signal && !flush;
    assign inflight  = {1'b0, count_q} + {{(PW+1){1'b0}}, outstanding_q};
    assign credit_ok = inflight < (PW+2)'(FIFO_DEPTH);

`ifdef STATIC_BTFN_EN
    logic [31:0] rsp_off;
    logic        pred_mem [FIFO_DEPTH];
    assign rsp_off    = b_offset(imem_rdata);
    assign pred_in    = push && rsp_off[31];
    assign pred_taken = out_valid && pred_mem[rd_ptr_q];
`else
    assign pred_in    = 1'b0;
    assign pred_taken = 1'b0;
`endif

    // A completing response frees the slot in the same cycle, allowing back-to-back issue.
    // A predicted-taken push suppresses the sequential request so the target goes out next.
    assign issue = !reset && !flush && !discard_q && !pred_in &&
                   (!outstanding_q || imem_rvalid) && credit_ok;
    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            req_pc_d      = fetch_pc_q;
            outstanding_d = 1'b1;
        end
`ifdef STATIC_BTFN_EN
        if (pred_in) fetch_pc_d = req_pc_q + rsp_off;
`endif
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        // A response landing in the flush cycle is dropped here; only a still-pending one needs discard.
        if (flush) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = new_pc & 32'hFFFF_FFFC;
            discard_d  = outstanding_q && !imem_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= 32'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= req_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
`ifdef STATIC_BTFN_EN
            pred_mem[wr_ptr_q] <= pred_in;
`endif
        end
    end

    assign curr_PC     = out_valid ? pc_mem[rd_ptr_q] : 32'd0;
    assign instruction = out_valid ? ins_mem[rd_ptr_q] : NOP;
    assign immediate   = $signed(b_offset(instruction)) >>> 2;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory with configurable latency,
// per-cycle vector table for the startup stream, scoreboard of expected head PCs.
module tb_fetch_stage;
`ifdef STATIC_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk, reset, block_signal, flush;
    logic [31:0] new_pc;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid, pred_taken;
    logic [31:0] curr_PC, instruction, immediate;

    fetch_stage dut (
        .clk(clk), .reset(reset), .block_signal(block_signal), .flush(flush),
        .new_pc(new_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .curr_PC(curr_PC), .instruction(instruction),
        .immediate(immediate), .pred_taken(pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        pred;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] sbq [$];
    int          n_chk, n_fail, pops, lat, pend_cnt;
    logic        pend;
    logic [31:0] pend_addr;
    logic        s_req, s_valid, s_pred;
    logic [31:0] s_addr, s_pc, s_ins, s_imm;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_0013;
            32'h104: return 32'h0000_0014;
            32'h108: return 32'h0000_0015;
            32'h10C: return 32'hFE00_0AE3;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        if (BTFN && p == 32'h10C) return 32'h100;
        return p + 32'd4;
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] p);
        return (p == 32'h10C) ? 32'hFFFF_FFFD : 32'd0;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic fill_queue(input logic [31:0] start);
        logic [31:0] p;
        sbq.delete();
        p = start;
        repeat (40) begin
            sbq.push_back(p);
            p = next_pc(p);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        #1;
        s_req = imem_req;   s_addr = imem_addr;
        s_valid = out_valid; s_pc = curr_PC;
        s_ins = instruction; s_imm = immediate; s_pred = pred_taken;
        if (imem_req) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imem_addr;
        end
        if (out_valid && !block_signal && !flush && !reset) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got pop of %h expected none", curr_PC);
            end else begin
                e = sbq.pop_front();
                check("sb_pc", pops, curr_PC, e);
                check("sb_ins", pops, instruction, mem_word(e));
                check("sb_imm", pops, immediate, exp_imm(e));
                check("sb_pred", pops, {31'd0, pred_taken},
                      {31'd0, BTFN && e == 32'h10C});
            end
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pend = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int base, k;
        logic got;
        reset = 1'b1; block_signal = 1'b0; flush = 1'b0; new_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        n_chk = 0; n_fail = 0; pops = 0; lat = 1; pend = 1'b0;
        pend_cnt = 0; pend_addr = 32'd0;

        tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h13, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h104, 1'b0, 32'h0,   32'h13, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 32'h108, 1'b1, 32'h100, 32'h13, 32'h0, 1'b0};
        tbl[3] = '{1'b1, 32'h10C, 1'b1, 32'h104, 32'h14, 32'h0, 1'b0};
        tbl[4] = '{!BTFN, 32'h110, 1'b1, 32'h108, 32'h15, 32'h0, 1'b0};
        tbl[5] = '{1'b1, BTFN ? 32'h100 : 32'h114, 1'b1, 32'h10C,
                   32'hFE00_0AE3, 32'hFFFF_FFFD, BTFN};

        // reset held two cycles, then startup stream
        fill_queue(32'h100);
        step();
        step();
        check("rst_req", 0, {31'd0, s_req}, 32'd0);
        check("rst_valid", 0, {31'd0, s_valid}, 32'd0);
        check("rst_ins", 0, s_ins, 32'h13);
        check("rst_pc", 0, s_pc, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_req", i, {31'd0, s_req}, {31'd0, tbl[i].req});
            if (tbl[i].req) check("t2_addr", i, s_addr, tbl[i].addr);
            check("t2_valid", i, {31'd0, s_valid}, {31'd0, tbl[i].valid});
            check("t2_pc", i, s_pc, tbl[i].pc);
            check("t2_ins", i, s_ins, tbl[i].ins);
            check("t2_imm", i, s_imm, tbl[i].imm);
            check("t2_pred", i, {31'd0, s_pred}, {31'd0, tbl[i].pred});
        end

        // stall: FIFO fills, requests stop, then drains in order
        do_reset();
        fill_queue(32'h100);
        block_signal = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i >= 2) check("t3_head", i, s_pc, 32'h100);
            if (i >= 4) check("t3_noreq", i, {31'd0, s_req}, 32'd0);
        end
        block_signal = 1'b0;
        base = pops;
        repeat (12) step();
        check("t3_pops", 0, pops - base, 12);

        // flush with a slow request in flight
        do_reset();
        lat = 5;
        fill_queue(32'h100);
        step();
        step();
        fill_queue(32'h110);
        flush = 1'b1; new_pc = 32'h113;
        step();
        flush = 1'b0;
        got = 1'b0; k = 0;
        while (!got && k < 20) begin
            step();
            got = s_req;
            k++;
        end
        check("t4_req_seen", 0, {31'd0, got}, 32'd1);
        check("t4_addr", 0, s_addr, 32'h110);
        got = 1'b0; k = 0;
        while (!got && k < 20) begin
            step();
            got = s_valid;
            k++;
        end
        check("t4_valid_seen", 0, {31'd0, got}, 32'd1);
        check("t4_pc", 0, s_pc, 32'h110);

        // flush together with block and with a push
        lat = 1;
        do_reset();
        fill_queue(32'h100);
        block_signal = 1'b1;
        repeat (4) step();
        fill_queue(32'h200);
        flush = 1'b1; new_pc = 32'h200;
        step();
        flush = 1'b0; block_signal = 1'b0;
        step();
        check("t5_valid_t1", 0, {31'd0, s_valid}, 32'd0);
        check("t5_ins_t1", 0, s_ins, 32'h13);
        check("t5_req_t1", 0, {31'd0, s_req}, 32'd1);
        check("t5_addr_t1", 0, s_addr, 32'h200);
        step();
        check("t5_valid_t2", 0, {31'd0, s_valid}, 32'd0);
        step();
        check("t5_valid_t3", 0, {31'd0, s_valid}, 32'd1);
        check("t5_pc_t3", 0, s_pc, 32'h200);

        // reset while a slow request is outstanding; late response must be ignored
        do_reset();
        lat = 5;
        fill_queue(32'h100);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("t5r_valid", 0, {31'd0, s_valid}, 32'd0);
        check("t5r_ins", 0, s_ins, 32'h13);
        check("t5r_pc", 0, s_pc, 32'd0);
        check("t5r_imm", 0, s_imm, 32'd0);
        check("t5r_pred", 0, {31'd0, s_pred}, 32'd0);
        check("t5r_req", 0, {31'd0, s_req}, 32'd1);
        check("t5r_addr", 0, s_addr, 32'h100);
        base = pops; k = 0;
        while (pops - base < 2 && k < 30) begin
            step();
            k++;
        end
        check("t5r_pops", 0, pops - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
